// File: rtl/multi_channel_siderec_if.sv
// rtl/multi_channel_siderec_if.sv - channel group and record stream bundle for multi_channel_siderec
interface multi_channel_siderec_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNTW  = 32
);
  logic                       rec_en;
  logic [NCH*WIDTH-1:0]       din;
  logic [NCH-1:0]             sh_valid;
  logic [NCH-1:0]             cl_ready;
  logic [NCH-1:0]             sh_ready;
  logic                       rec_valid;
  logic                       rec_ready;
  logic [NCH-1:0]             ispkt_out;
  logic [NCH-1:0]             busy_out;
  logic [NCH*WIDTH-1:0]       dout;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic [CNTW-1:0]            rec_total;

  modport master (
    output rec_en, din, sh_valid, cl_ready, rec_ready,
    input  sh_ready, rec_valid, ispkt_out, busy_out, dout, fifo_count, rec_total
  );

  modport slave (
    input  rec_en, din, sh_valid, cl_ready, rec_ready,
    output sh_ready, rec_valid, ispkt_out, busy_out, dout, fifo_count, rec_total
  );
endinterface

// File: rtl/multi_channel_siderec.sv
// rtl/multi_channel_siderec.sv - records NCH valid/ready channels into one shared snapshot FIFO
module multi_channel_siderec #(
  parameter int NCH   = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNTW  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_channel_siderec_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 * NCH + NCH * WIDTH;

  logic [NCH-1:0] recorded;
  logic [NCH-1:0] past_busy;
  logic [NCH-1:0] new_packet;
  logic [NCH-1:0] ready;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CNTW-1:0] total;
  logic [EW-1:0]  mem [DEPTH];
  logic [EW-1:0]  head;
  logic           full;
  logic           push;
  logic           pop;

  assign full = (count == CW'(DEPTH));

  // An unrecorded packet may only handshake when recording is off.
  always_comb begin
    new_packet = bus.sh_valid & ~recorded & {NCH{bus.rec_en && !full}};
    ready      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (recorded[i] || new_packet[i])
        ready[i] = bus.cl_ready[i];
      else if (!bus.rec_en && !recorded[i])
        ready[i] = bus.cl_ready[i];
      else
        ready[i] = 1'b0;
    end
  end

  assign push = |new_packet;
  assign pop  = bus.rec_valid && bus.rec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recorded  <= '0;
      past_busy <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      total     <= '0;
    end else begin
      recorded  <= bus.sh_valid & ~ready & (recorded | new_packet);
      past_busy <= bus.sh_valid & ~ready;
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (push && (total != '1))
        total <= total + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {new_packet, past_busy, bus.din};
  end

  // Storage is not reset, so the head is masked whenever the FIFO is empty.
  assign head          = bus.rec_valid ? mem[rd_ptr] : '0;
  assign bus.sh_ready  = ready;
  assign bus.rec_valid = (count != '0);
  assign bus.ispkt_out = head[EW-1 -: NCH];
  assign bus.busy_out  = head[NCH*WIDTH +: NCH];
  assign bus.dout      = head[NCH*WIDTH-1:0];
  assign bus.fifo_count = count;
  assign bus.rec_total = total;
endmodule

// File: tb/tb_multi_channel_siderec.sv
// tb/tb_multi_channel_siderec.sv - vector, corner-case and randomized checks for multi_channel_siderec
module tb_multi_channel_siderec;
  localparam int NCH   = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 6;
  localparam int TMAX  = (1 << CNTW) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  multi_channel_siderec_if #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  multi_channel_siderec #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic [3:0]  v;
    logic [3:0]  cr;
    logic        rr;
    logic [31:0] d0;
    logic [3:0]  e_rdy;
    logic        e_rv;
    logic [3:0]  e_ip;
    logic [3:0]  e_bz;
    logic [31:0] e_h0;
    int          e_cnt;
    int          e_tot;
  } vec_t;

  typedef struct {
    logic [3:0]   ip;
    logic [3:0]   bz;
    logic [127:0] d;
  } entry_t;

  vec_t        tbl [14];
  entry_t      mq [$];
  logic [3:0]  mrec;
  logic [3:0]  mpb;
  int          mtot;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic re, input logic [3:0] v, input logic [3:0] cr,
                       input logic rr, input logic [127:0] d);
    bus.rec_en    = re;
    bus.sh_valid  = v;
    bus.cl_ready  = cr;
    bus.rec_ready = rr;
    bus.din       = d;
  endtask

  function automatic logic [127:0] lanes(input logic [31:0] d0);
    return {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 4'b0000, 4'b1111, 1'b0, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [3:0]   v, cr, rdy, np, prev_rdy;
    logic         re, rr, full, ev;
    logic [31:0]  lane [4];
    logic [127:0] d;
    entry_t       hd, ne;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    drive(1'b1, 4'b0000, 4'b1111, 1'b0, '0);
    #2;
    chk("reset_rec_valid", bus.rec_valid, 0);
    chk("reset_count", bus.fifo_count, 0);
    chk("reset_total", bus.rec_total, 0);
    chk("reset_sh_ready", bus.sh_ready, 0);
    chk("reset_ispkt", bus.ispkt_out, 0);
    chk("reset_busy", bus.busy_out, 0);
    chk("reset_dout", bus.dout, 0);
    do_reset();

    tbl[0]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 32'h0,        4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        0, 0};
    tbl[1]  = '{1'b1, 4'b0001, 4'b1111, 1'b0, 32'hA5A5A5A5, 4'b0001, 1'b0, 4'b0000, 4'b0000, 32'h0,        0, 0};
    tbl[2]  = '{1'b1, 4'b0000, 4'b1111, 1'b0, 32'h0,        4'b0000, 1'b1, 4'b0001, 4'b0000, 32'hA5A5A5A5, 1, 1};
    tbl[3]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 32'h0,        4'b0000, 1'b1, 4'b0001, 4'b0000, 32'hA5A5A5A5, 1, 1};
    tbl[4]  = '{1'b1, 4'b0010, 4'b1101, 1'b0, 32'h100,      4'b0000, 1'b0, 4'b0000, 4'b0000, 32'h0,        0, 1};
    tbl[5]  = '{1'b1, 4'b0110, 4'b1101, 1'b0, 32'h200,      4'b0100, 1'b1, 4'b0010, 4'b0000, 32'h100,      1, 2};
    tbl[6]  = '{1'b1, 4'b0010, 4'b1101, 1'b0, 32'h300,      4'b0000, 1'b1, 4'b0010, 4'b0000, 32'h100,      2, 3};
    tbl[7]  = '{1'b1, 4'b0010, 4'b1111, 1'b1, 32'h300,      4'b0010, 1'b1, 4'b0010, 4'b0000, 32'h100,      2, 3};
    tbl[8]  = '{1'b1, 4'b0000, 4'b1111, 1'b1, 32'h0,        4'b0000, 1'b1, 4'b0100, 4'b0010, 32'h200,      1, 3};
    tbl[9]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 32'h400,      4'b1111, 1'b0, 4'b0000, 4'b0000, 32'h0,        0, 3};
    tbl[10] = '{1'b1, 4'b1111, 4'b1111, 1'b1, 32'h500,      4'b1111, 1'b1, 4'b1111, 4'b0000, 32'h400,      1, 4};
    tbl[11] = '{1'b1, 4'b0000, 4'b1111, 1'b0, 32'h0,        4'b0000, 1'b1, 4'b1111, 4'b0000, 32'h500,      1, 5};
    tbl[12] = '{1'b0, 4'b1010, 4'b0110, 1'b1, 32'h0,        4'b0110, 1'b1, 4'b1111, 4'b0000, 32'h500,      1, 5};
    tbl[13] = '{1'b0, 4'b1111, 4'b1001, 1'b0, 32'h0,        4'b1001, 1'b0, 4'b0000, 4'b0000, 32'h0,        0, 5};

    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].re, tbl[r].v, tbl[r].cr, tbl[r].rr, lanes(tbl[r].d0));
      #2;
      chk($sformatf("vec%0d_sh_ready", r), bus.sh_ready, tbl[r].e_rdy);
      chk($sformatf("vec%0d_rec_valid", r), bus.rec_valid, tbl[r].e_rv);
      chk($sformatf("vec%0d_ispkt", r), bus.ispkt_out, tbl[r].e_ip);
      chk($sformatf("vec%0d_busy", r), bus.busy_out, tbl[r].e_bz);
      chk($sformatf("vec%0d_dout0", r), bus.dout[31:0], tbl[r].e_h0);
      chk($sformatf("vec%0d_count", r), bus.fifo_count, tbl[r].e_cnt);
      chk($sformatf("vec%0d_total", r), bus.rec_total, tbl[r].e_tot);
      step();
    end

    // Pass-through: ten handshakes with recording disabled
    for (int k = 0; k < 10; k++) begin
      cr = 4'($urandom_range(1, 15));
      drive(1'b0, 4'b1111, cr, 1'b0, {4{32'($urandom)}});
      #2;
      chk("pass_sh_ready", bus.sh_ready, cr);
      step();
    end
    chk("pass_total", bus.rec_total, 5);

    // Full: four pushes, fifth source held until a pop frees a slot
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'b0001, 4'b1111, 1'b0, {96'h0, 32'(k)});
      #2;
      chk("full_fill_ready", bus.sh_ready, 4'b0001);
      step();
    end
    drive(1'b1, 4'b0010, 4'b1111, 1'b0, {32'h0, 32'h0, 32'h55, 32'h0});
    #2;
    chk("full_held_ready", bus.sh_ready, 4'b0000);
    chk("full_count", bus.fifo_count, 4);
    step();
    bus.rec_ready = 1'b1;
    #2;
    chk("full_pop_cycle_ready", bus.sh_ready, 4'b0000);
    chk("full_pop_head", bus.dout[31:0], 32'h0);
    step();
    bus.rec_ready = 1'b0;
    #2;
    chk("full_after_pop_count", bus.fifo_count, 3);
    chk("full_after_pop_ready", bus.sh_ready, 4'b0010);
    chk("full_after_pop_head", bus.dout[31:0], 32'h1);
    step();
    drive(1'b1, 4'b0000, 4'b1111, 1'b0, '0);
    #2;
    chk("full_refill_count", bus.fifo_count, 4);
    chk("full_refill_total", bus.rec_total, 5);

    // Reset mid-operation with ch0 recorded but stalled
    do_reset();
    drive(1'b1, 4'b0010, 4'b1111, 1'b0, '0);
    step();
    drive(1'b1, 4'b0100, 4'b1111, 1'b0, '0);
    step();
    drive(1'b1, 4'b0001, 4'b1110, 1'b0, {96'h0, 32'hC0DE});
    step();
    #2;
    chk("midrst_pre_count", bus.fifo_count, 3);
    chk("midrst_pre_ready", bus.sh_ready, 4'b0000);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rec_valid", bus.rec_valid, 0);
    chk("midrst_count", bus.fifo_count, 0);
    chk("midrst_total", bus.rec_total, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("midrst_rerecord_count", bus.fifo_count, 1);
    chk("midrst_rerecord_ispkt", bus.ispkt_out, 4'b0001);
    chk("midrst_rerecord_dout", bus.dout[31:0], 32'hC0DE);
    chk("midrst_rerecord_total", bus.rec_total, 1);

    // Randomized run against a queue-based reference model
    do_reset();
    mq.delete();
    mrec     = '0;
    mpb      = '0;
    mtot     = 0;
    re       = 1'b1;
    v        = '0;
    prev_rdy = '0;
    for (int i = 0; i < 4; i++) lane[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) re = ~re;
      for (int i = 0; i < 4; i++) begin
        if (!(v[i] && !prev_rdy[i] && $urandom_range(0, 9) != 0)) begin
          v[i]    = 1'($urandom_range(0, 1));
          lane[i] = $urandom;
        end
      end
      cr = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 9) < 4);
      d  = {lane[3], lane[2], lane[1], lane[0]};
      drive(re, v, cr, rr, d);
      #2;
      full = (mq.size() == DEPTH);
      np   = v & ~mrec & {4{re && !full}};
      for (int i = 0; i < 4; i++)
        rdy[i] = (mrec[i] || np[i] || !re) ? cr[i] : 1'b0;
      ev = (mq.size() != 0);
      hd = ev ? mq[0] : '{4'b0, 4'b0, 128'b0};
      chk("rnd_sh_ready", bus.sh_ready, rdy);
      chk("rnd_rec_valid", bus.rec_valid, ev);
      chk("rnd_ispkt", bus.ispkt_out, hd.ip);
      chk("rnd_busy", bus.busy_out, hd.bz);
      chk("rnd_dout", bus.dout, hd.d);
      chk("rnd_count", bus.fifo_count, mq.size());
      chk("rnd_total", bus.rec_total, mtot);
      if (ev && rr) void'(mq.pop_front());
      if (np != 0) begin
        ne = '{np, mpb, d};
        mq.push_back(ne);
        if (mtot < TMAX) mtot++;
      end
      mrec     = v & ~rdy & (mrec | np);
      mpb      = v & ~rdy;
      prev_rdy = rdy;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
